run_detector: RTL

- Parametrised, multi-channel successor to the single-input "w held high" sequence-detector FSM used on the DE1_SoC board.
- Each of CHANNELS switch or key inputs is synchronised, then run-length counted.
- A channel flags when its input has been continuously active for at least a programmable threshold of cycles. It also emits a one-cycle detection pulse and keeps a wrapping hit count.
- Sits between the board switches/keys and the LEDR/HEX display logic.

---
 rtl/run_det_pkg.sv | 28 ++
 rtl/run_channel.sv | 147 ++++++++++++++
 rtl/run_detector.sv | 58 +++++
 3 files changed

// File: rtl/run_det_pkg.sv
// run_det_pkg
// Shared types and default constants for the multi-channel run detector.
//   run_state_t : per-channel FSM state. The unused 2'b11 code is treated
//                 as illegal and recovers to IDLE on the next clock edge.
//   DEF_*       : default parameter values used by run_detector and run_channel.
//   is_legal_state : helper used by run_channel to spot the unused state code.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        DETECT = 2'b10
    } run_state_t;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_HIT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // The synchroniser needs at least two flops to be useful against
    // metastability; smaller requests are quietly raised to two.
    localparam int MIN_SYNC_STAGES = 2;

    function automatic logic is_legal_state(input run_state_t st);
        return (st == IDLE) || (st == RUN) || (st == DETECT);
    endfunction

endpackage

// File: rtl/run_channel.sv
// run_channel
// One detector channel: input synchroniser, saturating run-length counter,
// IDLE/RUN/DETECT state machine, detection strobe and wrapping hit counter.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (0 = reset)
//   en         count enable; 0 freezes run/state/out/hits and kills pulse
//   clear      synchronous clear of run, state, out, pulse and hits
//   pol        0 = detect runs of 1, 1 = detect runs of 0
//   threshold  run-length threshold T; 0 disables detection
//   w          raw asynchronous input
//   out        high while in DETECT
//   pulse      one-cycle strobe on entry to DETECT
//   hits       number of DETECT entries, wraps at 2^HIT_W
module run_channel
    import run_det_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HIT_W       = DEF_HIT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             pol,
    input  logic [CNT_W-1:0] threshold,
    input  logic             w,
    output logic             out,
    output logic             pulse,
    output logic [HIT_W-1:0] hits
);

    localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [HIT_W-1:0] HIT_ONE = {{(HIT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input synchroniser. Runs whenever reset is released, independent of
    // en and clear, so the sampled input never goes stale.
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] sync_reg;
    logic              s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_N-2:0], w};
        end
    end

    assign s = sync_reg[SYNC_N-1];

    // ------------------------------------------------------------------
    // Run-length arithmetic, computed from the current registered run.
    // ------------------------------------------------------------------
    logic             active;
    logic [CNT_W-1:0] run_reg;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] run_next;
    logic             reach;

    assign active   = s ^ pol;
    // Saturate instead of wrapping so a long run never looks short again.
    assign run_inc  = (run_reg == RUN_MAX) ? RUN_MAX : (run_reg + RUN_ONE);
    assign run_next = active ? run_inc : '0;
    // A threshold of zero means "never detect", not "always detect".
    assign reach    = active && (threshold != '0) && (run_next >= threshold);

    // ------------------------------------------------------------------
    // State machine with registered outputs.
    // ------------------------------------------------------------------
    run_state_t       state_reg;
    logic             out_reg;
    logic             pulse_reg;
    logic [HIT_W-1:0] hits_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            run_reg   <= '0;
            out_reg   <= 1'b0;
            pulse_reg <= 1'b0;
            hits_reg  <= '0;
        end else if (clear) begin
            // clear wins over en and over a DETECT entry on the same edge.
            state_reg <= IDLE;
            run_reg   <= '0;
            out_reg   <= 1'b0;
            pulse_reg <= 1'b0;
            hits_reg  <= '0;
        end else if (!en) begin
            // Frozen: everything holds except the strobe, which must not
            // repeat while the channel is paused.
            pulse_reg <= 1'b0;
            if (!is_legal_state(state_reg)) begin
                state_reg <= IDLE;
                run_reg   <= '0;
                out_reg   <= 1'b0;
            end
        end else begin
            pulse_reg <= 1'b0;
            case (state_reg)
                IDLE, RUN: begin
                    run_reg <= run_next;
                    if (!active) begin
                        state_reg <= IDLE;
                        out_reg   <= 1'b0;
                    end else if (reach) begin
                        state_reg <= DETECT;
                        out_reg   <= 1'b1;
                        pulse_reg <= 1'b1;
                        hits_reg  <= hits_reg + HIT_ONE;
                    end else begin
                        state_reg <= RUN;
                        out_reg   <= 1'b0;
                    end
                end
                DETECT: begin
                    // Hysteresis: once detected, only a break in the run
                    // (or clear) leaves DETECT, whatever T does meanwhile.
                    run_reg <= run_next;
                    if (!active) begin
                        state_reg <= IDLE;
                        out_reg   <= 1'b0;
                    end else begin
                        state_reg <= DETECT;
                        out_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    run_reg   <= '0;
                    out_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign out   = out_reg;
    assign pulse = pulse_reg;
    assign hits  = hits_reg;

endmodule

// File: rtl/run_detector.sv
// run_detector
// Multi-channel run-length detector sitting between board switches/keys and
// the LED/HEX display logic. Each channel is an independent run_channel; this
// level only fans out shared controls and slices the per-channel vectors.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (0 = reset)
//   en         count enable shared by all channels
//   clear      synchronous clear shared by all channels
//   pol        per-channel polarity (bit i -> channel i)
//   threshold  shared run-length threshold T; 0 disables detection
//   w          raw asynchronous channel inputs
//   out        per-channel DETECT level
//   pulse      per-channel one-cycle detection strobe
//   hits       per-channel hit counters, channel i at [i*HIT_W +: HIT_W]
module run_detector
    import run_det_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HIT_W       = DEF_HIT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       pol,
    input  logic [CNT_W-1:0]          threshold,
    input  logic [CHANNELS-1:0]       w,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS*HIT_W-1:0] hits
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            run_channel #(
                .CNT_W       (CNT_W),
                .HIT_W       (HIT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .en        (en),
                .clear     (clear),
                .pol       (pol[gi]),
                .threshold (threshold),
                .w         (w[gi]),
                .out       (out[gi]),
                .pulse     (pulse[gi]),
                .hits      (hits[gi*HIT_W +: HIT_W])
            );
        end
    endgenerate

endmodule
